// File: rtl/magia_tile_pkg.sv
// Shared tile-level definitions for the fractal sync tree: level width,
// fan-in of a tree node and the node FSM state encoding.
package magia_tile_pkg;

  localparam int FSYNC_LVL_W      = 2;
  localparam int FSYNC_N_CHILDREN = 2;

  typedef enum logic [1:0] {
    FSYNC_IDLE     = 2'd0,
    FSYNC_FWD      = 2'd1,
    FSYNC_WAIT_PAR = 2'd2,
    FSYNC_WAKE     = 2'd3
  } fsync_node_state_e;

endpackage

// File: rtl/fractal_sync_node_rx.sv
// Per-child request capture for a fractal sync node: holds the pending flag,
// the requested level and a sticky error for one child initiator.
module fractal_sync_node_rx #(
  parameter int LVL_W    = 2,
  parameter int NODE_LVL = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             sync_i,
  input  logic [LVL_W-1:0] level_i,
  input  logic             release_i,
  input  logic             drop_i,
  output logic             pend_o,
  output logic [LVL_W-1:0] lvl_o,
  output logic             err_o
);

  localparam logic [LVL_W-1:0] NodeLvl = LVL_W'(NODE_LVL);

  logic             pend_q, pend_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             err_q, err_d;

  // An ack or a level-mismatch drop frees the slot first, so a sync in the
  // same cycle is judged against the freed slot.
  always_comb begin
    pend_d = pend_q & ~release_i & ~drop_i;
    lvl_d  = lvl_q;
    err_d  = err_q | drop_i;
    if (sync_i) begin
      if ((level_i < NodeLvl) || pend_d) begin
        err_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        lvl_d  = level_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      lvl_q  <= '0;
      err_q  <= 1'b0;
    end else if (clear_i) begin
      pend_q <= 1'b0;
      lvl_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      lvl_q  <= lvl_d;
      err_q  <= err_d;
    end
  end

  assign pend_o = pend_q;
  assign lvl_o  = lvl_q;
  assign err_o  = err_q;

endmodule

// File: rtl/fractal_sync_node.sv
// Binary-tree node of the fractal sync network: resolves barriers at its own
// level, forwards higher-level barriers to the parent and relays the wake.
module fractal_sync_node
  import magia_tile_pkg::*;
#(
  parameter int LVL_W    = FSYNC_LVL_W,
  parameter int NODE_LVL = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic [1:0]         ch_sync_i,
  input  logic [2*LVL_W-1:0] ch_level_i,
  input  logic [1:0]         ch_ack_i,
  output logic [1:0]         ch_wake_o,
  output logic [1:0]         ch_error_o,
  output logic               par_sync_o,
  output logic [LVL_W-1:0]   par_level_o,
  output logic               par_ack_o,
  input  logic               par_wake_i,
  input  logic               par_error_i
);

  localparam logic [LVL_W-1:0] NodeLvl = LVL_W'(NODE_LVL);

  fsync_node_state_e  state_q;
  logic [1:0]         ack_seen_q;
  logic [1:0]         pend, err, ack_now, seen;
  logic [2*LVL_W-1:0] lvl;
  logic               lvl_match, drop;

  assign ch_wake_o   = (state_q == FSYNC_WAKE) ? ~ack_seen_q : 2'b00;
  assign ack_now     = ch_wake_o & ch_ack_i;
  assign seen        = ack_seen_q | ack_now;
  assign lvl_match   = (lvl[LVL_W-1:0] == lvl[2*LVL_W-1:LVL_W]);
  assign drop        = (state_q == FSYNC_IDLE) && (&pend) && !lvl_match;

  assign par_sync_o  = (state_q == FSYNC_FWD);
  assign par_level_o = par_sync_o ? lvl[LVL_W-1:0] : '0;
  assign par_ack_o   = (state_q == FSYNC_WAIT_PAR) && par_wake_i;
  assign ch_error_o  = err | {2{par_error_i}};

  for (genvar i = 0; i < FSYNC_N_CHILDREN; i++) begin : g_rx
    fractal_sync_node_rx #(
      .LVL_W    (LVL_W),
      .NODE_LVL (NODE_LVL)
    ) u_rx (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .sync_i    (ch_sync_i[i]),
      .level_i   (ch_level_i[i*LVL_W +: LVL_W]),
      .release_i (ack_now[i]),
      .drop_i    (drop),
      .pend_o    (pend[i]),
      .lvl_o     (lvl[i*LVL_W +: LVL_W]),
      .err_o     (err[i])
    );
  end

  // Levels of both children are equal once we leave IDLE, so child 0 decides.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FSYNC_IDLE;
      ack_seen_q <= 2'b00;
    end else if (clear_i) begin
      state_q    <= FSYNC_IDLE;
      ack_seen_q <= 2'b00;
    end else begin
      case (state_q)
        FSYNC_IDLE: begin
          if ((&pend) && lvl_match) begin
            state_q <= (lvl[LVL_W-1:0] == NodeLvl) ? FSYNC_WAKE : FSYNC_FWD;
          end
        end
        FSYNC_FWD: state_q <= FSYNC_WAIT_PAR;
        FSYNC_WAIT_PAR: begin
          if (par_wake_i) state_q <= FSYNC_WAKE;
        end
        FSYNC_WAKE: begin
          if (&seen) begin
            state_q    <= FSYNC_IDLE;
            ack_seen_q <= 2'b00;
          end else begin
            ack_seen_q <= seen;
          end
        end
        default: state_q <= FSYNC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fractal_sync_node.sv
// Self-checking bench for fractal_sync_node: directed barrier scenarios plus a
// randomized run, all compared against a barrier-level behavioural model.
module tb_fractal_sync_node;
  import magia_tile_pkg::*;

  localparam int LVL_W    = FSYNC_LVL_W;
  localparam int NODE_LVL = 1;
  localparam int PH_IDLE = 0, PH_FWD = 1, PH_WAITP = 2, PH_WAKE = 3;

  logic               clk_i = 1'b0;
  logic               rst_ni, clear_i;
  logic [1:0]         ch_sync_i, ch_ack_i;
  logic [2*LVL_W-1:0] ch_level_i;
  logic [1:0]         ch_wake_o, ch_error_o;
  logic               par_sync_o, par_ack_o, par_wake_i, par_error_i;
  logic [LVL_W-1:0]   par_level_o;

  int testsRun = 0;
  int testsFailed = 0;

  bit mPend[2];
  int mLvl[2];
  bit mErr[2];
  bit mSeen[2];
  int mPhase;

  fractal_sync_node #(.LVL_W(LVL_W), .NODE_LVL(NODE_LVL)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .ch_sync_i   (ch_sync_i),
    .ch_level_i  (ch_level_i),
    .ch_ack_i    (ch_ack_i),
    .ch_wake_o   (ch_wake_o),
    .ch_error_o  (ch_error_o),
    .par_sync_o  (par_sync_o),
    .par_level_o (par_level_o),
    .par_ack_o   (par_ack_o),
    .par_wake_i  (par_wake_i),
    .par_error_i (par_error_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mPend[i] = 0; mLvl[i] = 0; mErr[i] = 0; mSeen[i] = 0;
    end
    mPhase = PH_IDLE;
  endtask

  // Barrier rules: both children must request the same level; a level equal
  // to ours is answered locally, a higher one goes up and waits for the parent.
  task automatic modelStep(input logic [1:0] sync, input int l0, input int l1,
                           input logic [1:0] ack, input logic pw, input logic clr);
    bit acked[2];
    bit mismatch, allDone;
    int lv;
    if (clr) begin
      modelReset();
      return;
    end
    for (int i = 0; i < 2; i++) acked[i] = (mPhase == PH_WAKE) && ack[i] && !mSeen[i];
    mismatch = (mPhase == PH_IDLE) && mPend[0] && mPend[1] && (mLvl[0] != mLvl[1]);
    allDone  = (mSeen[0] || acked[0]) && (mSeen[1] || acked[1]);
    case (mPhase)
      PH_IDLE:  if (mPend[0] && mPend[1] && !mismatch)
                  mPhase = (mLvl[0] == NODE_LVL) ? PH_WAKE : PH_FWD;
      PH_FWD:   mPhase = PH_WAITP;
      PH_WAITP: if (pw) mPhase = PH_WAKE;
      default: begin
        if (allDone) begin
          mPhase = PH_IDLE; mSeen[0] = 0; mSeen[1] = 0;
        end else begin
          for (int i = 0; i < 2; i++) mSeen[i] = mSeen[i] || acked[i];
        end
      end
    endcase
    for (int i = 0; i < 2; i++) begin
      mPend[i] = mPend[i] && !acked[i] && !mismatch;
      mErr[i]  = mErr[i] || mismatch;
      if (sync[i]) begin
        lv = (i == 0) ? l0 : l1;
        if (lv < NODE_LVL || mPend[i]) mErr[i] = 1;
        else begin
          mPend[i] = 1; mLvl[i] = lv;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare all outputs
  // against the model, then advance the model across the rising edge.
  task automatic applyStimulus(input logic [1:0] sync, input int l0, input int l1,
                               input logic [1:0] ack, input logic pw, input logic pe,
                               input logic clr);
    logic [1:0] eWake;
    ch_sync_i   = sync;
    ch_level_i  = {LVL_W'(l1), LVL_W'(l0)};
    ch_ack_i    = ack;
    par_wake_i  = pw;
    par_error_i = pe;
    clear_i     = clr;
    #1;
    for (int i = 0; i < 2; i++) eWake[i] = (mPhase == PH_WAKE) && !mSeen[i];
    checkOutput("ch_wake", ch_wake_o, eWake);
    checkOutput("ch_error", ch_error_o, {mErr[1] || pe, mErr[0] || pe});
    checkOutput("par_sync", par_sync_o, mPhase == PH_FWD);
    checkOutput("par_level", par_level_o, (mPhase == PH_FWD) ? mLvl[0] : 0);
    checkOutput("par_ack", par_ack_o, (mPhase == PH_WAITP) && pw);
    @(posedge clk_i);
    modelStep(sync, l0, l1, ack, pw, clr);
    @(negedge clk_i);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] rs, ra;
    logic rpw, rpe, rclr;
    rst_ni = 1'b0; clear_i = 1'b0; ch_sync_i = '0; ch_level_i = '0;
    ch_ack_i = '0; par_wake_i = 1'b0; par_error_i = 1'b0;
    modelReset();
    #3;
    checkOutput("rst_wake", ch_wake_o, 2'b00);
    checkOutput("rst_error", ch_error_o, 2'b00);
    checkOutput("rst_par_sync", par_sync_o, 1'b0);
    checkOutput("rst_par_ack", par_ack_o, 1'b0);
    par_error_i = 1'b1;
    #1 checkOutput("rst_par_error", ch_error_o, 2'b11);
    par_error_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Local barrier at our own level
    idleCycles(2);
    applyStimulus(2'b11, 1, 1, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t1_wake_t2", ch_wake_o, 2'b11);
    applyStimulus(2'b00, 0, 0, 2'b11, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t1_wake_drop", ch_wake_o, 2'b00);
    idleCycles(2);

    // Forwarded barrier at level 3
    applyStimulus(2'b11, 3, 3, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t2_par_sync", par_sync_o, 1'b1);
    checkOutput("t2_par_level", par_level_o, 3);
    idleCycles(2);
    applyStimulus(2'b00, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("t2_wake", ch_wake_o, 2'b11);
    applyStimulus(2'b00, 0, 0, 2'b11, 1'b0, 1'b0, 1'b0);
    idleCycles(1);

    // Level mismatch, then clear
    applyStimulus(2'b11, 2, 1, 2'b00, 1'b0, 1'b0, 1'b0);
    idleCycles(3);
    #1 checkOutput("t3_sticky_err", ch_error_o, 2'b11);
    applyStimulus(2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("t3_cleared", ch_error_o, 2'b00);

    // Illegal level, then double sync, then completing the barrier
    applyStimulus(2'b01, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b10, 0, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t4_fwd_level", par_level_o, 2);
    idleCycles(1);
    applyStimulus(2'b00, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0);

    // Staggered acks with an early re-sync from child 0
    applyStimulus(2'b00, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 1, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("t5_wake1_held", ch_wake_o, 2'b10);
    idleCycles(2);
    applyStimulus(2'b00, 0, 0, 2'b10, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b10, 0, 1, 2'b00, 1'b0, 1'b0, 1'b0);
    idleCycles(1);
    #1 checkOutput("t5_rebarrier", ch_wake_o, 2'b11);
    applyStimulus(2'b00, 0, 0, 2'b11, 1'b0, 1'b0, 1'b1);

    // Clear while waiting on the parent
    applyStimulus(2'b11, 3, 3, 2'b00, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(2'b00, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
    par_wake_i = 1'b1;
    #1 checkOutput("t6_no_ack", par_ack_o, 1'b0);
    applyStimulus(2'b00, 0, 0, 2'b00, 1'b1, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rs[0] = ($urandom_range(0, 4) == 0);
      rs[1] = ($urandom_range(0, 4) == 0);
      ra[0] = ($urandom_range(0, 2) == 0);
      ra[1] = ($urandom_range(0, 2) == 0);
      rpw   = (mPhase == PH_WAITP) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rpe   = ($urandom_range(0, 39) == 0);
      rclr  = ($urandom_range(0, 149) == 0);
      applyStimulus(rs, $urandom_range(0, 3), $urandom_range(0, 3), ra, rpw, rpe, rclr);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
